// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier with start/busy/done handshake.
// One partial-product bit per cycle; result commits on the final iteration.
module mul_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mq;
  logic [WIDTH:0]    acc;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH:0]  shifted;
  logic              last_iter;

  always_comb begin
    sum       = acc + (mq[0] ? {1'b0, mcand} : '0);
    shifted   = {sum, mq} >> 1;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: product/valid only change on the edge that finishes the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      mq      <= '0;
      acc     <= '0;
      product <= '0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= shifted[2*WIDTH:WIDTH];
          mq  <= shifted[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            product <= shifted[2*WIDTH-1:0];
            done    <= 1'b1;
            valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl at WIDTH=4 (plus one WIDTH=8 instance).
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  a = '0, b = '0;
  logic        busy, done, valid;
  logic [7:0]  product;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, valid8;
  logic [15:0] product8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .valid(valid), .product(product)
  );

  mul_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .valid(valid8), .product(product8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns just after the accept edge.
  task automatic launch(input logic [3:0] av, input logic [3:0] bv);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({busy, done, valid, product} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_w4: got busy=%b done=%b valid=%b product=%h, want all 0", busy, done, valid, product);
    end
    n_cmp++;
    if ({busy8, done8, valid8, product8} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_w8: got busy=%b done=%b valid=%b product=%h, want all 0", busy8, done8, valid8, product8);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    launch(4'hF, 4'hF);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_after_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || valid !== 1'b0 || product !== 8'h00) begin
        n_err++;
        $display("FAIL basic_calc_edge%0d: got done=%b valid=%b product=%h, want 0/0/00", i, done, valid, product);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b1 || product !== 8'hE1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_result: got done=%b valid=%b busy=%b product=%h, want 1/1/1/e1", done, valid, busy, product);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b1 || product !== 8'hE1) begin
      n_err++;
      $display("FAIL basic_after_done: got done=%b busy=%b valid=%b product=%h, want 0/0/1/e1", done, busy, valid, product);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || product !== 8'hE1) begin
      n_err++;
      $display("FAIL basic_idle: got busy=%b product=%h, want 0/e1", busy, product);
    end
  endtask

  task automatic test_zero_and_one();
    int lat; bit seen;
    logic [3:0] av [2] = '{4'h0, 4'h7};
    logic [3:0] bv [2] = '{4'h9, 4'h1};
    logic [7:0] ev [2] = '{8'h00, 8'h07};
    for (int k = 0; k < 2; k++) begin
      launch(av[k], bv[k]);
      wait_done(lat, seen);
      n_cmp++;
      if (!seen || lat != 4 || product !== ev[k]) begin
        n_err++;
        $display("FAIL zero_one_%0d: got seen=%b lat=%0d product=%h, want 1/4/%h", k, seen, lat, product, ev[k]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    launch(4'd3, 4'd5);
    tick();
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    if (done) dones++;
    tick();
    if (done) dones++;
    tick();
    if (done) dones++;
    n_cmp++;
    if (done !== 1'b1 || product !== 8'h0F) begin
      n_err++;
      $display("FAIL ignore_result: got done=%b product=%h, want 1/0f", done, product);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (done) dones++;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_busy_drop: got busy=%b, want 0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    n_cmp++;
    if (dones != 1 || product !== 8'h0F || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_single_done: got dones=%0d product=%h busy=%b, want 1/0f/0", dones, product, busy);
    end
  endtask

  task automatic test_async_reset();
    int lat; bit seen;
    launch(4'd6, 4'd7);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, valid, product} !== 11'd0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b valid=%b product=%h, want all 0", busy, done, valid, product);
    end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_no_done: got stray_done_or_valid=%b busy=%b, want 0/0", seen, busy);
    end
    launch(4'd2, 4'd3);
    wait_done(lat, seen);
    n_cmp++;
    if (!seen || lat != 4 || product !== 8'h06) begin
      n_err++;
      $display("FAIL async_restart: got seen=%b lat=%0d product=%h, want 1/4/06", seen, lat, product);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int times [$];
    bit stable_ok = 1'b1;
    a = 4'd5; b = 4'd5; start = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done) begin
        times.push_back(t);
        if (product !== 8'h19) stable_ok = 1'b0;
      end
      if (times.size() > 0 && product !== 8'h19) stable_ok = 1'b0;
    end
    start = 1'b0;
    n_cmp++;
    if (times.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", times.size());
    end else begin
      n_cmp++;
      if (times[0] != 5 || times[1] != 11 || times[2] != 17) begin
        n_err++;
        $display("FAIL b2b_timing: got done at %0d,%0d,%0d, want 5,11,17", times[0], times[1], times[2]);
      end
    end
    n_cmp++;
    if (!stable_ok) begin
      n_err++;
      $display("FAIL b2b_product: got product %h (unstable or wrong), want 19", product);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_width8();
    bit seen = 1'b0;
    int lat = 0;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (done8) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    n_cmp++;
    if (!seen || lat != 8 || product8 !== 16'hFE01 || valid8 !== 1'b1) begin
      n_err++;
      $display("FAIL width8: got seen=%b lat=%0d valid=%b product=%h, want 1/8/1/fe01", seen, lat, valid8, product8);
    end
    tick();
  endtask

  task automatic test_sweep();
    int lat; bit seen;
    logic [7:0] expv;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        expv = 8'(i * j);
        launch(4'(i), 4'(j));
        wait_done(lat, seen);
        n_cmp++;
        if (!seen || lat != 4 || product !== expv) begin
          n_err++;
          $display("FAIL sweep %0d*%0d: got seen=%b lat=%0d product=%h, want 1/4/%h", i, j, seen, lat, product, expv);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_and_one();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_width8();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
